fifo_rd_arb: RTL

Read-side scheduler that drains several asynchronous FIFOs' read ports into one registered output stream, in the FIFOs' read clock domain. Picks a non-empty, enabled source round-robin and holds the grant for a burst of up to BURST words, driving that FIFO's `rinc` only when a word can be accepted. It sits between the FIFO read interfaces (`rinc`/`rempty`/read data) and a single downstream consumer with valid/ready flow control.

---
 rtl/fifo_arb_pkg.sv | 24 ++
 rtl/rr_pick.sv | 33 +++
 rtl/fifo_rd_arb.sv | 137 +++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO read-side scheduler: FSM encodings and
// width helpers for source indices and burst counters.
package fifo_arb_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  // Index width for n sources; never below one bit.
  function automatic int unsigned src_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Burst counter width; one spare bit so the count never wraps at BURST=256.
  function automatic int unsigned cnt_w(input int unsigned b);
    return $clog2(b) + 1;
  endfunction

  localparam int unsigned DEF_NUM_SRC = 4;
  localparam int unsigned DEF_DSIZE   = 8;
  localparam int unsigned DEF_BURST   = 4;
  localparam int unsigned DEF_SRC_W   = src_w(DEF_NUM_SRC);
  localparam int unsigned DEF_CNT_W   = cnt_w(DEF_BURST);

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating priority encoder: first set request at or after
// the start pointer, wrapping modulo N.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned N  = DEF_NUM_SRC,
  localparam int unsigned IW = src_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          hit,
  output logic [IW-1:0] idx
);

  logic [IW:0] pos;

  always_comb begin
    hit = 1'b0;
    idx = '0;
    pos = '0;
    for (int unsigned i = 0; i < N; i++) begin
      pos = {1'b0, start} + (IW+1)'(i);
      if (pos >= (IW+1)'(N)) begin
        pos = pos - (IW+1)'(N);
      end
      if (!hit && req[pos[IW-1:0]]) begin
        hit = 1'b1;
        idx = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_rd_arb.sv
// Round-robin burst scheduler draining several FIFO read ports into one
// registered valid/ready stream, all in the FIFO read clock domain.
module fifo_rd_arb
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned NUM_SRC = DEF_NUM_SRC,
  parameter  int unsigned DSIZE   = DEF_DSIZE,
  parameter  int unsigned BURST   = DEF_BURST,
  localparam int unsigned SW      = src_w(NUM_SRC),
  localparam int unsigned CW      = cnt_w(BURST)
) (
  input  logic                     rclk,
  input  logic                     rrst,
  input  logic [NUM_SRC-1:0]       src_en,
  input  logic [NUM_SRC-1:0]       rempty,
  input  logic [NUM_SRC*DSIZE-1:0] rdata,
  output logic [NUM_SRC-1:0]       rinc,
  output logic                     m_valid,
  output logic [DSIZE-1:0]         m_data,
  output logic [SW-1:0]            m_src,
  output logic                     m_last,
  input  logic                     m_ready,
  output logic                     busy
);

  logic [0:0]       state, state_nxt;
  logic [SW-1:0]    ptr, ptr_nxt;
  logic [SW-1:0]    gnt, gnt_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             pick_hit;
  logic [SW-1:0]    pick_idx;
  logic [DSIZE-1:0] sel_data;
  logic             sel_empty;
  logic             sel_en;
  logic             can_take;
  logic             pop;
  logic             last_word;
  logic [SW-1:0]    ptr_after;

  rr_pick #(.N(NUM_SRC)) u_pick (
    .req   (src_en & ~rempty),
    .start (ptr),
    .hit   (pick_hit),
    .idx   (pick_idx)
  );

  // Granted source's data and status, without variable-index reach past NUM_SRC.
  always_comb begin
    sel_data  = '0;
    sel_empty = 1'b1;
    sel_en    = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (gnt == SW'(i)) begin
        sel_data  = rdata[i*DSIZE +: DSIZE];
        sel_empty = rempty[i];
        sel_en    = src_en[i];
      end
    end
  end

  always_comb begin
    can_take  = !m_valid || m_ready;
    pop       = (state == ST_BURST) && !rrst && !sel_empty && sel_en && can_take;
    last_word = (cnt == CW'(BURST - 1));
    ptr_after = (gnt == SW'(NUM_SRC - 1)) ? '0 : gnt + SW'(1);
  end

  always_comb begin
    rinc = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      rinc[i] = pop && (gnt == SW'(i));
    end
  end

  // Next-state logic: arbitrate in IDLE, count pops and detect burst end in BURST.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gnt_nxt   = gnt;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (pick_hit) begin
          gnt_nxt   = pick_idx;
          cnt_nxt   = '0;
          state_nxt = ST_BURST;
        end
      end
      ST_BURST: begin
        if (pop) begin
          cnt_nxt = cnt + CW'(1);
        end
        if (sel_empty || !sel_en || (pop && last_word)) begin
          ptr_nxt   = ptr_after;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state <= ST_IDLE;
      ptr   <= '0;
      gnt   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      gnt   <= gnt_nxt;
      cnt   <= cnt_nxt;
      busy  <= (state_nxt == ST_BURST);
    end
  end

  // Output register: loads on pop, drains on handshake, otherwise holds.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_src   <= '0;
      m_last  <= 1'b0;
    end else if (pop) begin
      m_valid <= 1'b1;
      m_data  <= sel_data;
      m_src   <= gnt;
      m_last  <= last_word;
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule
